// File: rtl/tipi_sout_pkg.sv
// rtl/tipi_sout_pkg.sv - shared types and constants for the shift-out sequencer
package tipi_sout_pkg;

  localparam int BITS        = 8;
  localparam int DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // A lone request wins outright; on a tie the requester not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
    return ~last;
  endfunction

endpackage

// File: rtl/shift_out_sequencer_if.sv
// rtl/shift_out_sequencer_if.sv - requester/host signal bundle for the shift-out sequencer
interface shift_out_sequencer_if;

  logic [1:0] req;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [1:0] gnt;
  logic       busy;
  logic       sclk;
  logic       sdout;
  logic       sle;
  logic       done;
  logic       owner;

  modport master (
    output req, byte0, byte1,
    input  gnt, busy, sclk, sdout, sle, done, owner
  );

  modport slave (
    input  req, byte0, byte1,
    output gnt, busy, sclk, sdout, sle, done, owner
  );

endinterface

// File: rtl/sout_phase_timer.sv
// rtl/sout_phase_timer.sv - half-period down-counter, reloaded on every phase entry
module sout_phase_timer
  import tipi_sout_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam logic [7:0] RELOAD = 8'(DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = (cnt == 8'd0);

endmodule

// File: rtl/shift_out_sequencer.sv
// rtl/shift_out_sequencer.sv - two-requester round-robin byte serializer with latch strobe
module shift_out_sequencer
  import tipi_sout_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_out_sequencer_if.slave  bus
);

  state_t          state;
  state_t          state_nx;
  logic            expire;
  logic            load;
  logic            take;
  logic            pick;
  logic            last;
  logic            owner_q;
  logic [BITS-1:0] shreg;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_inc;
  logic            bit_term;

  // reset gates take so no grant can leak out while reset is held
  assign take = (state == IDLE) && (bus.req != 2'b00) && !reset;
  assign pick = rr_pick(bus.req, last);
  assign load = take || ((state != IDLE) && expire);
  assign {bit_term, bit_inc} = {1'b0, bit_cnt} + 4'd1;

  sout_phase_timer #(.DIV(DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (take)   state_nx = SHIFT_LO;
      SHIFT_LO: if (expire) state_nx = SHIFT_HI;
      SHIFT_HI: if (expire) state_nx = bit_term ? LATCH : SHIFT_LO;
      LATCH:    if (expire) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt  = 2'b00;
    if (take) bus.gnt = pick ? 2'b10 : 2'b01;
    bus.busy = (state != IDLE);
    bus.sclk = (state == SHIFT_HI);
    bus.sle  = (state == LATCH);
    bus.done = (state == LATCH) && expire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= 3'd0;
      last    <= 1'b1;
      owner_q <= 1'b0;
    end else if (take) begin
      shreg   <= pick ? bus.byte1 : bus.byte0;
      bit_cnt <= 3'd0;
      last    <= pick;
      owner_q <= pick;
    end else if ((state == SHIFT_HI) && expire) begin
      shreg   <= {shreg[BITS-2:0], 1'b0};
      bit_cnt <= bit_inc;
    end
  end

  assign bus.sdout = shreg[BITS-1];
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_shift_out_sequencer.sv
// tb/tb_shift_out_sequencer.sv - model-checked randomized bench for shift_out_sequencer (DIV=4 and DIV=1)
module tb_shift_out_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] byte0;
  logic [7:0] byte1;

  shift_out_sequencer_if bus0 ();
  shift_out_sequencer_if bus1 ();

  assign bus0.req   = req;
  assign bus0.byte0 = byte0;
  assign bus0.byte1 = byte1;
  assign bus1.req   = req;
  assign bus1.byte0 = byte0;
  assign bus1.byte1 = byte1;

  shift_out_sequencer #(.DIV(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  shift_out_sequencer #(.DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  // packed view: {gnt[1:0], busy, sclk, sdout, sle, done, owner}
  logic [7:0] o_vec [2];
  assign o_vec[0] = {bus0.gnt, bus0.busy, bus0.sclk, bus0.sdout, bus0.sle, bus0.done, bus0.owner};
  assign o_vec[1] = {bus1.gnt, bus1.busy, bus1.sclk, bus1.sdout, bus1.sle, bus1.done, bus1.owner};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // transfer-level model: m_t = cycles since grant (0 = idle)
  int         m_t     [2];
  logic       m_last  [2];
  logic       m_owner [2];
  logic [7:0] m_byte  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    for (int d = 0; d < 2; d++) begin
      int         dv;
      int         t;
      logic [1:0] eg;
      logic       eb, esc, esd, esl, edn, g;
      dv = (d == 0) ? 4 : 1;
      eg = 2'b00; eb = 1'b0; esc = 1'b0; esd = 1'b0; esl = 1'b0; edn = 1'b0; g = 1'b0;
      if (reset) begin
        m_t[d] = 0; m_last[d] = 1'b1; m_owner[d] = 1'b0;
      end else if (m_t[d] == 0) begin
        if (req != 2'b00) begin
          if (req == 2'b11) g = (m_last[d] == 1'b0);
          else              g = (req == 2'b10);
          eg = g ? 2'b10 : 2'b01;
        end
      end else begin
        t  = m_t[d];
        eb = 1'b1;
        if (t <= 16 * dv) begin
          esc = (((t - 1) / dv) % 2) == 1;
          esd = m_byte[d][7 - (t - 1) / (2 * dv)];
        end else begin
          esl = 1'b1;
          edn = (t == 17 * dv);
        end
      end
      check($sformatf("dut%0d outputs {gnt,busy,sclk,sdout,sle,done,owner}", d),
            32'(o_vec[d]), 32'({eg, eb, esc, esd, esl, edn, m_owner[d]}));
      if (!reset) begin
        if (m_t[d] == 0) begin
          if (eg != 2'b00) begin
            m_t[d] = 1; m_byte[d] = g ? byte1 : byte0; m_last[d] = g; m_owner[d] = g;
          end
        end else if (m_t[d] == 17 * dv) begin
          m_t[d] = 0;
        end else begin
          m_t[d]++;
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_xfer(input int d, input logic [1:0] r, input logic [7:0] b0, input logic [7:0] b1,
                          input int drop_at, input int budget,
                          output int gc, output int dc, output int s0, output int sn, output int ng,
                          output logic [7:0] bits, output logic [1:0] gv);
    int   k;
    logic prev_sclk;
    req = r; byte0 = b0; byte1 = b1;
    gc = -1; dc = -1; s0 = -1; sn = 0; ng = 0; bits = 8'h00; gv = 2'b00; prev_sclk = 1'b0; k = 0;
    while (k < budget && dc < 0) begin
      sample();
      if (o_vec[d][7:6] != 2'b00) begin
        ng++;
        if (gc < 0) begin gc = k; gv = o_vec[d][7:6]; end
      end
      if (o_vec[d][4] && !prev_sclk) bits = {bits[6:0], o_vec[d][3]};
      prev_sclk = o_vec[d][4];
      if (o_vec[d][2]) begin
        if (sn == 0) s0 = k;
        sn++;
      end
      if (o_vec[d][1]) dc = k;
      adv();
      k++;
      if (k == drop_at) req = 2'b00;
    end
  endtask

  task automatic wait_idle(input int budget);
    int   k;
    logic idle;
    k = 0; idle = 1'b0;
    while (!idle && k < budget) begin
      sample();
      idle = !o_vec[0][5] && !o_vec[1][5];
      adv();
      k++;
    end
    check("wait_idle reached", 32'(idle), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         gc, dc, s0, sn, ng, nd, k;
    logic [7:0] bits;
    logic [1:0] gv;
    int         gcs [3];
    int         dcs [3];
    logic [1:0] gvs [3];

    reset = 1'b1; req = 2'b00; byte0 = 8'h00; byte1 = 8'h00;
    for (int d = 0; d < 2; d++) begin
      m_t[d] = 0; m_last[d] = 1'b1; m_owner[d] = 1'b0; m_byte[d] = 8'h00;
    end
    repeat (3) begin sample(); adv(); end
    reset = 1'b0;
    sample(); adv();

    // DIV=4, byte0=A5, req[0] dropped while busy
    run_xfer(0, 2'b01, 8'hA5, 8'h3C, 10, 120, gc, dc, s0, sn, ng, bits, gv);
    check("A gnt cycle", 32'(gc), 32'd0);
    check("A gnt value", 32'(gv), 32'h1);
    check("A serial bits", 32'(bits), 32'hA5);
    check("A sle first cycle", 32'(s0), 32'd65);
    check("A sle length", 32'(sn), 32'd4);
    check("A done cycle", 32'(dc), 32'd68);
    nd = 0;
    repeat (20) begin
      sample();
      if (o_vec[0][7:6] != 2'b00) nd++;
      adv();
    end
    check("A no regrant after drop", 32'(nd), 32'd0);

    // DIV=1, byte1=80
    run_xfer(1, 2'b10, 8'h00, 8'h80, 1, 40, gc, dc, s0, sn, ng, bits, gv);
    check("B gnt value", 32'(gv), 32'h2);
    check("B serial bits", 32'(bits), 32'h80);
    check("B done cycle", 32'(dc), 32'd17);
    check("B sle length", 32'(sn), 32'd1);
    wait_idle(200);

    // both requesting continuously: alternating grants, back-to-back
    req = 2'b11; byte0 = 8'h0F; byte1 = 8'hF0;
    for (int i = 0; i < 3; i++) begin gcs[i] = -1; dcs[i] = -1; gvs[i] = 2'b00; end
    ng = 0; nd = 0; k = 0;
    while (ng < 3 && k < 300) begin
      sample();
      if (o_vec[0][7:6] != 2'b00) begin gcs[ng] = k; gvs[ng] = o_vec[0][7:6]; ng++; end
      if (o_vec[0][1] && nd < 3) begin dcs[nd] = k; nd++; end
      adv();
      k++;
    end
    req = 2'b00;
    check("C grant count", 32'(ng), 32'd3);
    check("C grant 0", 32'(gvs[0]), 32'h1);
    check("C grant 1", 32'(gvs[1]), 32'h2);
    check("C grant 2", 32'(gvs[2]), 32'h1);
    check("C regrant after done 0", 32'(gcs[1]), 32'(dcs[0] + 1));
    check("C regrant after done 1", 32'(gcs[2]), 32'(dcs[1] + 1));
    check("C grant spacing", 32'(gcs[1] - gcs[0]), 32'd69);
    wait_idle(200);

    // reset in the middle of a transfer
    req = 2'b01; byte0 = 8'h5A; nd = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (o_vec[0][1]) nd++;
      adv();
    end
    reset = 1'b1; req = 2'b00;
    #1;
    check("D dut0 outputs under reset", 32'(o_vec[0]), 32'd0);
    check("D dut1 outputs under reset", 32'(o_vec[1]), 32'd0);
    check("D no done before abort", 32'(nd), 32'd0);
    repeat (2) begin sample(); adv(); end
    reset = 1'b0;
    sample();
    check("D no gnt at release without req", 32'(o_vec[0][7:6]), 32'd0);
    adv();
    run_xfer(0, 2'b10, 8'h00, 8'hC3, 1, 120, gc, dc, s0, sn, ng, bits, gv);
    check("D gnt value after reset", 32'(gv), 32'h2);
    check("D serial bits after reset", 32'(bits), 32'hC3);
    check("D done cycle after reset", 32'(dc), 32'd68);
    wait_idle(200);

    // randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        req   = 2'($urandom_range(0, 3));
        byte0 = 8'($urandom);
        byte1 = 8'($urandom);
      end
      if (!reset && $urandom_range(0, 299) == 0) reset = 1'b1;
      else reset = 1'b0;
      sample();
      adv();
    end
    reset = 1'b0; req = 2'b00;
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_out_sequencer.md
SHIFT_OUT_SEQUENCER -- requirements
Module: shift_out_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clk cycles per sclk half-period; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req  input  2  per-requester transfer request, level; bit 0 data channel, bit 1 control channel.
REQ-005 SHALL have port byte0  input  8  byte offered by requester 0, valid while req[0]=1.
REQ-006 SHALL have port byte1  input  8  byte offered by requester 1, valid while req[1]=1.
REQ-007 SHALL have port gnt  output  2  one-hot, one-cycle pulse marking the cycle the granted byte is captured.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port sclk  output  1  serial clock to host.
REQ-010 SHALL have port sdout  output  1  serial data, MSB first.
REQ-011 SHALL have port sle  output  1  latch strobe to host after the 8th bit.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of transfer.
REQ-013 SHALL have port owner  output  1  index of the requester currently or last served.

Function
REQ-014 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-015 In IDLE with req!=0: SHALL pulse gnt, load the granted byte into an 8-bit shift register, set owner, clear the bit counter, and enter SHIFT_LO; gnt is combinational from IDLE and req in that cycle.
REQ-016 Arbitration SHALL be round-robin: single request is granted; on simultaneous requests, the requester not granted last wins; the last-grant pointer resets to 1 so req[0] wins the first tie.
REQ-017 SHIFT_LO SHALL hold sclk=0 for DIV cycles, then enter SHIFT_HI.
REQ-018 SHIFT_HI SHALL hold sclk=1 for DIV cycles; on its last cycle, shift the register left with 0 fill and increment the bit counter (3-bit, plus terminal flag).
REQ-019 SHALL enter SHIFT_LO after SHIFT_HI for bits 1..7 and LATCH after the 8th bit.
REQ-020 sdout SHALL always equal shift register bit 7, so each bit is stable for the whole sclk low+high period.
REQ-021 LATCH SHALL hold sle=1 and sclk=0 for DIV cycles; done SHALL pulse on the last LATCH cycle, then return to IDLE.
REQ-022 Timing, gnt at cycle 0: SHIFT cycles 1..16*DIV, LATCH cycles 16*DIV+1..17*DIV, done at cycle 17*DIV; the earliest next gnt is cycle 17*DIV+1.
REQ-023 req changes while busy SHALL be ignored; a requester holding req after its gnt SHALL receive another transfer under round-robin rules.
REQ-024 The half-period counter SHALL be 8 bits and reload to DIV-1 on each state entry; DIV=1 SHALL give one cycle per phase.

Reset
REQ-025 Reset SHALL force, asynchronously: state IDLE, shift register 0, counters 0, pointer 1, owner 0.
REQ-026 Under reset, outputs SHALL be: gnt=00, busy=0, sclk=0, sdout=0, sle=0, done=0.
REQ-027 Reset mid-transfer SHALL abort with no done pulse, and no gnt SHALL be issued in the cycle reset deasserts unless req is present.

Structure
REQ-028 Package tipi_sout_pkg SHALL hold the state enum, BITS=8, and DIV_DEFAULT=4.
REQ-029 One sub-module, sout_phase_timer, SHALL contain the DIV half-period counter with load/expire signals; the FSM, arbiter and shift register stay in the top module.

Verification
REQ-030 Scenario: DIV=4, req=01, byte0=A5 -> gnt=01 at c0; sdout 1,0,1,0,0,1,0,1 sampled on sclk rising edges; sle high c65..c68; done at c68.
REQ-031 Scenario: req=11 held continuously, byte0=0F, byte1=F0 -> grants alternate 01,10,01; each next gnt exactly 1 cycle after done.
REQ-032 Scenario: DIV=1, byte1=80 -> sclk toggles every cycle; sdout=1 only for bit 0; done at c17.
REQ-033 Scenario: reset asserted at c20 mid-transfer -> all outputs 0 immediately; no done; a new req after release gets gnt with a fresh 8-bit shift.
REQ-034 Scenario: req[0] drops at c10 while busy -> transfer completes normally and done at c68; no new gnt afterwards.
